// File: rtl/sram_pkg.sv
// Shared types, default timing and sizing helpers for the SRAM front-end.
package sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWsetup,
    StWpulse,
    StWhold,
    StRd,
    StTurn
  } sram_state_e;

  localparam int unsigned DefAw     = 15;
  localparam int unsigned DefDw     = 8;
  localparam int unsigned DefWrWait = 2;
  localparam int unsigned DefRdWait = 2;
  localparam int unsigned DefTurn   = 1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold a count of n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((2 ** w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Host-side request/response bus of the SRAM controller.
interface sram_ctrl_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 8
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          wr_ack;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, wr_ack
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, wr_ack
  );

endinterface

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter; done while the count is at (or below) one.
module sram_wait_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Load on state entry, otherwise count down and park at one.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)               cnt_d = load_val_i;
    else if (cnt_q > W'(1))   cnt_d = cnt_q - W'(1);
  end

  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous front-end sequencing CEB/WEB/OEB for an asynchronous SRAM.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned WR_WAIT = DefWrWait,
  parameter int unsigned RD_WAIT = DefRdWait,
  parameter int unsigned TURN    = DefTurn
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_ctrl_if.slave    bus,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_ceb,
  output logic          sram_web,
  output logic          sram_oeb
);

  localparam int unsigned CntW  = cnt_width(max2(WR_WAIT, RD_WAIT));
  localparam int unsigned TurnW = cnt_width(TURN);

  localparam logic [CntW-1:0]  WrLoad   = CntW'(WR_WAIT);
  localparam logic [CntW-1:0]  RdLoad   = CntW'(RD_WAIT);
  localparam logic [TurnW-1:0] TurnLoad = TurnW'(TURN);

  sram_state_e state_q, state_d;

  logic          accept;
  logic          wait_load, wait_done;
  logic [CntW-1:0] wait_val;
  logic          turn_load, turn_done;

  logic          ceb_q, ceb_d;
  logic          web_q, web_d;
  logic          oeb_q, oeb_d;
  logic          dq_oe_q, dq_oe_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dq_o_q, dq_o_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          wr_ack_q, wr_ack_d;

  assign bus.req_ready = (state_q == StIdle);
  assign accept        = bus.req_valid && bus.req_ready;

  // Wait-state counter shared by WPULSE and RD; reloaded on entry to either.
  assign wait_load = ((state_d == StWpulse) && (state_q != StWpulse)) ||
                     ((state_d == StRd) && (state_q != StRd));
  assign wait_val  = (state_d == StRd) ? RdLoad : WrLoad;

  sram_wait_cnt #(
    .W (CntW)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wait_load),
    .load_val_i (wait_val),
    .done_o     (wait_done)
  );

  assign turn_load = (state_d == StTurn) && (state_q != StTurn);

  sram_wait_cnt #(
    .W (TurnW)
  ) u_turn_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (turn_load),
    .load_val_i (TurnLoad),
    .done_o     (turn_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.req_valid) state_d = bus.req_we ? StWsetup : StRd;
      StWsetup: state_d = StWpulse;
      StWpulse: if (wait_done) state_d = StWhold;
      StWhold:  state_d = StIdle;
      StRd:     if (wait_done) state_d = (TURN != 0) ? StTurn : StIdle;
      StTurn:   if (turn_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output next-values, decoded from the upcoming state so the pins are flop outputs.
  always_comb begin
    ceb_d   = 1'b1;
    web_d   = 1'b1;
    oeb_d   = 1'b1;
    dq_oe_d = 1'b0;
    unique case (state_d)
      StWsetup, StWhold: begin
        ceb_d   = 1'b0;
        dq_oe_d = 1'b1;
      end
      StWpulse: begin
        ceb_d   = 1'b0;
        web_d   = 1'b0;
        dq_oe_d = 1'b1;
      end
      StRd: begin
        ceb_d = 1'b0;
        oeb_d = 1'b0;
      end
      default: ;
    endcase
    wr_ack_d    = (state_d == StWhold);
    addr_d      = accept ? bus.req_addr : addr_q;
    dq_o_d      = (accept && bus.req_we) ? bus.req_wdata : dq_o_q;
    // Capture on the edge that ends the last RD cycle.
    rsp_valid_d = (state_q == StRd) && wait_done;
    rsp_rdata_d = rsp_valid_d ? sram_dq_i : rsp_rdata_q;
  end

  // Output registers; reset drops every strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ceb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      dq_oe_q     <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_ack_q    <= 1'b0;
    end else begin
      ceb_q       <= ceb_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      dq_oe_q     <= dq_oe_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  assign sram_ceb      = ceb_q;
  assign sram_web      = web_q;
  assign sram_oeb      = oeb_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_addr     = addr_q;
  assign sram_dq_o     = dq_o_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.wr_ack    = wr_ack_q;

endmodule
